// File: rtl/poly_select_stream_if.sv
// rtl/poly_select_stream_if.sv - start/stream bundle for poly_select_stream
//   in_flat     : NUM_IN packed polynomials, channel c at [c*N*COEFF_W +: N*COEFF_W]
//   sel         : channel to capture, sampled on the start handshake
//   start_valid / start_ready : capture request handshake
//   out_data / out_valid / out_ready / out_last / out_beat : coefficient beat stream
//   busy        : streaming in progress
//   sel_err     : one-cycle pulse after a start with an out-of-range sel

`ifndef KYBER_N
`define KYBER_N 256
`endif

interface poly_select_stream_if #(
  parameter int NUM_IN  = 5,
  parameter int N       = `KYBER_N,
  parameter int COEFF_W = 12,
  parameter int LANES   = 4
);
  localparam int SEL_W     = $clog2(NUM_IN);
  localparam int NUM_BEATS = N / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic [NUM_IN*N*COEFF_W-1:0] in_flat;
  logic [SEL_W-1:0]            sel;
  logic                        start_valid;
  logic                        start_ready;
  logic [LANES*COEFF_W-1:0]    out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic [BEAT_W-1:0]           out_beat;
  logic                        busy;
  logic                        sel_err;

  modport master (
    output in_flat, sel, start_valid, out_ready,
    input  start_ready, out_data, out_valid, out_last, out_beat, busy, sel_err
  );

  modport slave (
    input  in_flat, sel, start_valid, out_ready,
    output start_ready, out_data, out_valid, out_last, out_beat, busy, sel_err
  );
endinterface

// File: rtl/poly_select_stream.sv
// rtl/poly_select_stream.sv - capture one of NUM_IN polynomials and stream it LANES coefficients per beat
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : poly_select_stream_if.slave (start handshake in, beat stream out)
//   Optional macro POLY_SEL_STREAM_REDUCE_EN: each output lane is conditionally
//   reduced by KYBER_Q (single subtraction) on the way out of the buffer.

`ifndef KYBER_N
`define KYBER_N 256
`endif
`ifndef KYBER_Q
`define KYBER_Q 3329
`endif

module poly_select_stream #(
  parameter int NUM_IN  = 5,
  parameter int N       = `KYBER_N,
  parameter int COEFF_W = 12,
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  poly_select_stream_if.slave    bus
);
  localparam int SEL_W     = $clog2(NUM_IN);
  localparam int NUM_BEATS = N / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int POLY_W    = N * COEFF_W;
  localparam int DATA_W    = LANES * COEFF_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  // One extra bit so channel counts that are powers of two compare correctly.
  localparam logic [SEL_W:0]    NUM_IN_W  = (SEL_W + 1)'(NUM_IN);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [POLY_W-1:0]   buffer_q, buffer_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                start_ready_q, start_ready_d;
  logic                sel_err_q, sel_err_d;

  logic                sel_bad;
  logic [DATA_W-1:0]   lanes;
  logic [COEFF_W-1:0]  coeff;

  assign sel_bad = {1'b0, bus.sel} >= NUM_IN_W;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    buffer_d      = buffer_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    busy_d        = busy_q;
    start_ready_d = start_ready_q;
    sel_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          if (sel_bad) begin
            sel_err_d = 1'b1;
          end else begin
            for (int c = 0; c < NUM_IN; c++) begin
              if (bus.sel == SEL_W'(c)) begin
                buffer_d = bus.in_flat[c*POLY_W +: POLY_W];
              end
            end
            state_d       = STREAM;
            beat_d        = '0;
            out_valid_d   = 1'b1;
            busy_d        = 1'b1;
            start_ready_d = 1'b0;
            out_last_d    = (LAST_BEAT == '0);
          end
        end
      end

      STREAM: begin
        if (bus.out_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d       = IDLE;
            beat_d        = '0;
            out_valid_d   = 1'b0;
            out_last_d    = 1'b0;
            busy_d        = 1'b0;
            start_ready_d = 1'b1;
          end else begin
            beat_d     = beat_q + 1'b1;
            out_last_d = ((beat_q + 1'b1) == LAST_BEAT);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
      sel_err_q     <= sel_err_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset term.
  always_ff @(posedge clk) begin
    buffer_q <= buffer_d;
  end

  // Lanes are sliced straight from the buffer; buffer and beat only change on
  // a handshake, so the beat holds stable under backpressure.
  always_comb begin
    lanes = '0;
    coeff = '0;
    for (int k = 0; k < LANES; k++) begin
      coeff = buffer_q[(int'(beat_q) * LANES + k) * COEFF_W +: COEFF_W];
`ifdef POLY_SEL_STREAM_REDUCE_EN
      // Single conditional subtraction, not a full modular reduction.
      if (coeff >= COEFF_W'(`KYBER_Q)) begin
        coeff = coeff - COEFF_W'(`KYBER_Q);
      end
`else
`endif
      lanes[k*COEFF_W +: COEFF_W] = coeff;
    end
  end

  assign bus.out_data    = out_valid_q ? lanes : '0;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_beat    = beat_q;
  assign bus.busy        = busy_q;
  assign bus.start_ready = start_ready_q;
  assign bus.sel_err     = sel_err_q;
endmodule

// File: tb/tb_poly_select_stream.sv
// tb/tb_poly_select_stream.sv - directed table-driven bench for poly_select_stream

module tb_poly_select_stream;
  localparam int NUM_IN    = 5;
  localparam int N         = 256;
  localparam int COEFF_W   = 12;
  localparam int LANES     = 4;
  localparam int NUM_BEATS = N / LANES;
  localparam int BEAT_W    = $clog2(NUM_BEATS);
  localparam int SEL_W     = $clog2(NUM_IN);
  localparam int DW        = LANES * COEFF_W;

  typedef struct {
    int sel;
    bit rand_ready;
    bit bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_select_stream_if #(.NUM_IN(NUM_IN), .N(N), .COEFF_W(COEFF_W), .LANES(LANES)) bus ();

  poly_select_stream #(.NUM_IN(NUM_IN), .N(N), .COEFF_W(COEFF_W), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int ref_mem [NUM_IN][N];
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int red(input int v);
`ifdef POLY_SEL_STREAM_REDUCE_EN
    return (v >= 3329) ? v - 3329 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input int ch, input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[k*COEFF_W +: COEFF_W] = COEFF_W'(red(ref_mem[ch][b*LANES + k]));
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ref_to_bus;
    for (int c = 0; c < NUM_IN; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.in_flat[(c*N + i)*COEFF_W +: COEFF_W] = COEFF_W'(ref_mem[c][i]);
      end
    end
  endtask

  task automatic fill_pattern;
    for (int c = 0; c < NUM_IN; c++) begin
      for (int i = 0; i < N; i++) begin
        ref_mem[c][i] = (c*256 + i) % 4096;
      end
    end
    load_ref_to_bus();
  endtask

  task automatic start(input int s);
    check("start_ready_idle", 64'(bus.start_ready), 64'd1);
    bus.sel = SEL_W'(s);
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
  endtask

  // Entered in the cycle after the start handshake; checks every cycle until
  // all beats are accepted, then the idle cycle that follows.
  task automatic stream(input int ch, input bit rnd);
    int b;
    int cyc;
    logic [63:0] act;
    logic [63:0] exp;
    b = 0;
    cyc = 0;
    while (b < NUM_BEATS && cyc < 2000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      act = 64'({bus.out_valid, bus.out_last, bus.busy, bus.start_ready, bus.out_beat, bus.out_data});
      exp = 64'({1'b1, (b == NUM_BEATS - 1), 1'b1, 1'b0, BEAT_W'(b), exp_data(ch, b)});
      check($sformatf("beat ch%0d b%0d", ch, b), act, exp);
      if (bus.out_ready) b++;
      tick();
      cyc++;
    end
    check("stream_beats_done", 64'(b), 64'(NUM_BEATS));
    check("after_last {valid,last,busy,ready}",
          64'({bus.out_valid, bus.out_last, bus.busy, bus.start_ready}), 64'b0001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp0;

    vecs[0] = '{sel: 3, rand_ready: 1'b0, bad: 1'b0};
    vecs[1] = '{sel: 5, rand_ready: 1'b0, bad: 1'b1};
    vecs[2] = '{sel: 7, rand_ready: 1'b0, bad: 1'b1};
    vecs[3] = '{sel: 1, rand_ready: 1'b0, bad: 1'b0};
    vecs[4] = '{sel: 0, rand_ready: 1'b1, bad: 1'b0};
    vecs[5] = '{sel: 6, rand_ready: 1'b0, bad: 1'b1};
    vecs[6] = '{sel: 2, rand_ready: 1'b1, bad: 1'b0};
    vecs[7] = '{sel: 4, rand_ready: 1'b0, bad: 1'b0};

    bus.in_flat = '0;
    bus.sel = '0;
    bus.start_valid = 1'b0;
    bus.out_ready = 1'b0;
    fill_pattern();

    rst_n = 1'b0;
    tick();
    tick();
    check("reset outputs {valid,last,busy,sel_err,beat,data}",
          64'({bus.out_valid, bus.out_last, bus.busy, bus.sel_err, bus.out_beat, bus.out_data}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset start_ready", 64'(bus.start_ready), 64'd1);
    check("post_reset out_valid", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].sel);
      if (vecs[i].bad) begin
        check($sformatf("sel_err pulse sel%0d {err,valid,ready}", vecs[i].sel),
              64'({bus.sel_err, bus.out_valid, bus.start_ready}), 64'b101);
        tick();
        check($sformatf("sel_err clear sel%0d {err,valid,ready}", vecs[i].sel),
              64'({bus.sel_err, bus.out_valid, bus.start_ready}), 64'b001);
      end else begin
        stream(vecs[i].sel, vecs[i].rand_ready);
      end
    end

    // Input overwritten right after capture must not reach the stream.
    start(4);
    bus.in_flat = '1;
    stream(4, 1'b0);
    load_ref_to_bus();

    // Reset while beat 20 is presented.
    start(0);
    for (int b = 0; b < 20; b++) begin
      bus.out_ready = 1'b1;
      tick();
    end
    check("abort at beat", 64'(bus.out_beat), 64'd20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort {valid,busy,ready,last,beat,data}",
          64'({bus.out_valid, bus.busy, bus.start_ready, bus.out_last, bus.out_beat, bus.out_data}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, BEAT_W'(0), DW'(0)}));
    for (int j = 0; j < 3; j++) begin
      tick();
      check("post_abort {valid,last}", 64'({bus.out_valid, bus.out_last}), 64'd0);
    end
    start(2);
    stream(2, 1'b0);

    // Conditional-reduction pattern on channel 2.
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: ref_mem[2][i] = 3328;
        1: ref_mem[2][i] = 3329;
        2: ref_mem[2][i] = 4000;
        default: ref_mem[2][i] = 0;
      endcase
    end
    load_ref_to_bus();
`ifdef POLY_SEL_STREAM_REDUCE_EN
    exp0 = {12'd0, 12'd671, 12'd0, 12'd3328};
`else
    exp0 = {12'd0, 12'd4000, 12'd3329, 12'd3328};
`endif
    start(2);
    check("reduce lanes beat0", 64'(bus.out_data), 64'(exp0));
    stream(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/poly_select_stream.md
Name: poly_select_stream

Overview:
Parametrised successor to the fixed 5-to-1 polynomial multiplexer in the add datapath. It accepts NUM_IN packed polynomials and a channel select under a valid/ready start handshake. It captures the selected polynomial into an internal buffer, then streams it out LANES coefficients per beat with valid/ready backpressure and a last flag. It sits between the polynomial register bank and the serial add/reduce pipeline.

Parameters:
NUM_IN, 5, number of input polynomial channels (>=2)
N, `KYBER_N (256), coefficients per polynomial
COEFF_W, 12, bits per coefficient
LANES, 4, coefficients per output beat; N % LANES == 0 required
SEL_W, $clog2(NUM_IN), select width (derived, localparam)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_flat  input  NUM_IN*N*COEFF_W  channel c occupies [c*N*COEFF_W +: N*COEFF_W]; coefficient i of a channel occupies [i*COEFF_W +: COEFF_W]
sel  input  SEL_W  channel to capture; sampled only on start handshake
start_valid  input  1  request to capture and stream in_flat[sel]
start_ready  output  1  high only in IDLE
out_data  output  LANES*COEFF_W  lane k = coefficient beat*LANES+k at [k*COEFF_W +: COEFF_W]
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts beat
out_last  output  1  high with final beat (beat == N/LANES-1)
out_beat  output  $clog2(N/LANES)  index of the current beat
busy  output  1  high in STREAM
sel_err  output  1  one-cycle pulse on start with sel >= NUM_IN

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, beat=0, out_valid=0, out_last=0, out_data=0, out_beat=0, busy=0, sel_err=0, buffer contents don't-care. start_ready=1 from the first cycle after reset is released.
- States: IDLE, STREAM.
- IDLE: start_ready=1. On start_valid && sel<NUM_IN: buffer <= in_flat channel sel, beat <= 0, go to STREAM.
- IDLE with start_valid && sel>=NUM_IN: sel_err=1 for the following cycle only; stay in IDLE; buffer unchanged; no beats are emitted.
- Start-to-first-beat latency is 1 cycle: out_valid=1 in the cycle after the handshake.
- in_flat is ignored after capture. Changes to the inputs during STREAM do not affect the output.
- STREAM: busy=1, start_ready=0, out_valid=1, out_data=buffer coefficients [beat*LANES .. beat*LANES+LANES-1], out_beat=beat.
- STREAM with out_valid && out_ready: beat increments. If !out_ready: out_data, out_beat and out_last hold stable (AXI-stream rule; valid never drops without a handshake).
- Final beat (beat==N/LANES-1) accepted: next cycle state=IDLE, out_valid=0, out_last=0, beat=0, start_ready=1.
- No back-to-back overlap: a new start is accepted only in IDLE. Minimum gap between the last beat and the next first beat is 1 cycle.
- Beat counter wraps only via the return to IDLE; it never exceeds N/LANES-1.
- Reset mid-stream: abort immediately to the reset state. The remaining beats are discarded and out_last is never emitted.
- Data is a pure copy with no arithmetic, unless the optional feature is enabled.

Optional Feature:
POLY_SEL_STREAM_REDUCE_EN
- Defined: each output lane is conditionally reduced: if coeff >= `KYBER_Q (3329) then coeff-3329, else coeff. The reduction is combinational on the buffered value, so latency is unchanged. Values >= 6658 are only reduced once; this is not a full mod.
- Undefined: lanes pass the buffered coefficients unmodified.

Test Plan:
- Load channels 0-4 with coefficient i of channel c = (c*256+i) mod 4096. Start sel=3 with out_ready held 1 -> out_valid one cycle later. Exactly 64 beats, beat 0 lanes = 0x300,0x301,0x302,0x303. out_last only on beat 63 = 0x3FC..0x3FF. start_ready=1 on the next cycle.
- Start sel=5 and sel=7 -> sel_err pulses 1 cycle each, out_valid stays 0, start_ready stays 1. A following start with sel=1 then streams correctly from 0x100.
- Toggle out_ready randomly (50%) during sel=0 stream -> out_data/out_beat are stable whenever valid&&!ready. All 64 beats arrive in order with no duplicates or drops.
- Overwrite in_flat with all 0xFFF after the start handshake -> the streamed data still matches the captured pre-change values.
- Assert rst_n=0 for 1 cycle at beat 20 -> next cycle out_valid=0, busy=0, start_ready=1, no out_last. A restart streams from beat 0.
- With POLY_SEL_STREAM_REDUCE_EN, channel 2 coefficients = 3328, 3329, 4000, 0 repeated -> lanes = 3328, 0, 671, 0. Without the macro -> 3328, 3329, 4000, 0.
